// File: rtl/debounce_pkg.sv
// Shared types and defaults for the clkB-domain debounce stage.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        CHK_HIGH  = 2'd1,
        IDLE_HIGH = 2'd2,
        CHK_LOW   = 2'd3
    } db_state_t;

    localparam int unsigned DEF_STABLE_CYCLES = 16;
    localparam int unsigned DEF_EV_W          = 8;
    localparam int unsigned DEF_GL_W          = 8;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_edge.sv
// Debounces an already-synchronized level, emits one-cycle rise/fall pulses,
// and keeps a wrapping edge counter and a saturating glitch counter.
module debounce_edge
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned EV_W          = DEF_EV_W,
    parameter int unsigned GL_W          = DEF_GL_W
) (
    input  logic            clkB,
    input  logic            rst_clkB,
    input  logic            SignalIn_clkB,
    input  logic            cnt_clr,
    output logic            level_out_clkB,
    output logic            rise_clkB,
    output logic            fall_clkB,
    output logic [EV_W-1:0] edge_cnt,
    output logic [GL_W-1:0] glitch_cnt
);

    localparam int unsigned      CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 2) begin : g_bad_param
        $error("debounce_edge: STABLE_CYCLES must be at least 2");
    end

    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [EV_W-1:0]  edge_q, edge_d;
    logic [GL_W-1:0]  glitch_q, glitch_d;
    logic             edge_inc;
    logic             glitch_inc;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        level_d    = level_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        edge_inc   = 1'b0;
        glitch_inc = 1'b0;

        case (state_q)
            IDLE_LOW: begin
                if (SignalIn_clkB) begin
                    state_d = CHK_HIGH;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            CHK_HIGH: begin
                if (!SignalIn_clkB) begin
                    state_d    = IDLE_LOW;
                    cnt_d      = '0;
                    glitch_inc = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = IDLE_HIGH;
                    cnt_d    = '0;
                    level_d  = 1'b1;
                    rise_d   = 1'b1;
                    edge_inc = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IDLE_HIGH: begin
                if (!SignalIn_clkB) begin
                    state_d = CHK_LOW;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            CHK_LOW: begin
                if (SignalIn_clkB) begin
                    state_d    = IDLE_HIGH;
                    cnt_d      = '0;
                    glitch_inc = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = IDLE_LOW;
                    cnt_d    = '0;
                    level_d  = 1'b0;
                    fall_d   = 1'b1;
                    edge_inc = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // A clear in the same cycle as an increment wins; that increment is dropped.
    always_comb begin
        edge_d   = edge_q;
        glitch_d = glitch_q;
        if (cnt_clr) begin
            edge_d   = '0;
            glitch_d = '0;
        end else begin
            if (edge_inc) begin
                edge_d = edge_q + EV_W'(1);
            end
            if (glitch_inc && (glitch_q != '1)) begin
                glitch_d = glitch_q + GL_W'(1);
            end
        end
    end

    always_ff @(posedge clkB) begin
        if (rst_clkB) begin
            state_q  <= IDLE_LOW;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            edge_q   <= '0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            edge_q   <= edge_d;
            glitch_q <= glitch_d;
        end
    end

    assign level_out_clkB = level_q;
    assign rise_clkB      = rise_q;
    assign fall_clkB      = fall_q;
    assign edge_cnt       = edge_q;
    assign glitch_cnt     = glitch_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Directed, table-driven bench for debounce_edge with STABLE_CYCLES=4, 2-bit counters.
module tb_debounce_edge;

    localparam int unsigned SC = 4;
    localparam int unsigned EV = 2;
    localparam int unsigned GL = 2;

    logic          clkB = 1'b0;
    logic          rst_clkB;
    logic          SignalIn_clkB;
    logic          cnt_clr;
    logic          level_out_clkB;
    logic          rise_clkB;
    logic          fall_clkB;
    logic [EV-1:0] edge_cnt;
    logic [GL-1:0] glitch_cnt;

    debounce_edge #(
        .STABLE_CYCLES(SC),
        .EV_W         (EV),
        .GL_W         (GL)
    ) dut (
        .clkB          (clkB),
        .rst_clkB      (rst_clkB),
        .SignalIn_clkB (SignalIn_clkB),
        .cnt_clr       (cnt_clr),
        .level_out_clkB(level_out_clkB),
        .rise_clkB     (rise_clkB),
        .fall_clkB     (fall_clkB),
        .edge_cnt      (edge_cnt),
        .glitch_cnt    (glitch_cnt)
    );

    always #5 clkB = ~clkB;

    // exp packs {level, rise, fall, edge_cnt[1:0], glitch_cnt[1:0]} after the edge.
    typedef struct {
        logic       rst;
        logic       din;
        logic       clr;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic rst, input logic din, input logic clr,
                       input logic lvl, input logic r, input logic f,
                       input logic [1:0] e, input logic [1:0] g);
        vec_t v;
        v.rst = rst;
        v.din = din;
        v.clr = clr;
        v.exp = {lvl, r, f, e, g};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {lvl,rise,fall,edge,glitch}=%b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {level_out_clkB, rise_clkB, fall_clkB, edge_cnt, glitch_cnt};
    endfunction

    task automatic step(input logic rst, input logic din, input logic clr);
        rst_clkB      = rst;
        SignalIn_clkB = din;
        cnt_clr       = clr;
        @(posedge clkB);
        #1;
    endtask

    initial begin
        int          n;
        int unsigned g;
        logic        v;
        logic [1:0]  ep;

        rst_clkB      = 1'b1;
        SignalIn_clkB = 1'b0;
        cnt_clr       = 1'b0;

        // Idle after reset
        for (int i = 0; i < 3; i++)  add(1, 0, 0, 0, 0, 0, 2'd0, 2'd0);
        for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 0, 2'd0, 2'd0);

        // Accepted rise then accepted fall
        for (int i = 0; i < 3; i++)  add(0, 1, 0, 0, 0, 0, 2'd0, 2'd0);
        add(0, 1, 0, 1, 1, 0, 2'd1, 2'd0);
        add(0, 1, 0, 1, 0, 0, 2'd1, 2'd0);
        for (int i = 0; i < 3; i++)  add(0, 0, 0, 1, 0, 0, 2'd1, 2'd0);
        add(0, 0, 0, 0, 0, 1, 2'd2, 2'd0);
        add(0, 0, 0, 0, 0, 0, 2'd2, 2'd0);

        // Five rejected glitches; glitch_cnt saturates at 3
        for (int k = 1; k <= 5; k++) begin
            g = (k - 1 > 3) ? 3 : k - 1;
            for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 2'd2, 2'(g));
            g = (k > 3) ? 3 : k;
            add(0, 0, 0, 0, 0, 0, 2'd2, 2'(g));
        end

        // Edge counter wrap: 1, 2, 3, 0
        add(1, 0, 0, 0, 0, 0, 2'd0, 2'd0);
        for (int k = 1; k <= 4; k++) begin
            v  = (k % 2 == 1);
            ep = 2'((k - 1) % 4);
            for (int i = 0; i < 3; i++) add(0, v, 0, !v, 0, 0, ep, 2'd0);
            add(0, v, 0, v, v, !v, 2'(k % 4), 2'd0);
        end

        // Rise, fall, a low-side glitch, then clear on a rise commit edge
        for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 2'd0, 2'd0);
        add(0, 1, 0, 1, 1, 0, 2'd1, 2'd0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 0, 2'd1, 2'd0);
        add(0, 0, 0, 0, 0, 1, 2'd2, 2'd0);
        add(0, 1, 0, 0, 0, 0, 2'd2, 2'd0);
        add(0, 0, 0, 0, 0, 0, 2'd2, 2'd1);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 2'd2, 2'd1);
        add(0, 1, 1, 1, 1, 0, 2'd0, 2'd0);

        // High-side glitch (CHK_LOW abort), then a real fall
        add(0, 0, 0, 1, 0, 0, 2'd0, 2'd0);
        add(0, 0, 0, 1, 0, 0, 2'd0, 2'd0);
        add(0, 1, 0, 1, 0, 0, 2'd0, 2'd1);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 0, 2'd0, 2'd1);
        add(0, 0, 0, 0, 0, 1, 2'd1, 2'd1);

        // Reset mid-qualification with input held high
        add(0, 1, 0, 0, 0, 0, 2'd1, 2'd1);
        add(0, 1, 0, 0, 0, 0, 2'd1, 2'd1);
        add(1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
        add(1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 2'd0, 2'd0);
        add(0, 1, 0, 1, 1, 0, 2'd1, 2'd0);
        add(0, 1, 0, 1, 0, 0, 2'd1, 2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].din, vecs[i].clr);
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Hand sequence: latency from first high sample to rise pulse, bounded wait
        step(1, 0, 0);
        check("reset_state", outs(), 7'b000_00_00);
        SignalIn_clkB = 1'b1;
        rst_clkB      = 1'b0;
        n = 0;
        do begin
            @(posedge clkB);
            #1;
            n++;
        end while (!rise_clkB && n < 20);
        checks++;
        if (n != SC) begin
            errors++;
            $display("FAIL rise_latency: got %0d edges expected %0d", n, SC);
        end
        check("rise_commit", outs(), 7'b110_01_00);
        step(0, 1, 0);
        check("rise_one_cycle", outs(), 7'b100_01_00);

        // Hand sequence: clear wins over a same-edge glitch increment
        step(0, 0, 0);
        check("chk_low_entry", outs(), 7'b100_01_00);
        step(0, 1, 1);
        check("clr_beats_glitch", outs(), 7'b100_00_00);
        step(0, 1, 0);
        check("after_clr_hold", outs(), 7'b100_00_00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
